ped_signal: RTL
===============

PED_SIGNAL -- requirements
Module: ped_signal

Interface
REQ-001 Parameter CLK_HZ, default 1000000, clk cycles per second.
REQ-002 Parameter PED_S, default 25, pedestrian phase length in seconds, 1..99; SHALL equal the P-phase length of main_ltc.
REQ-003 Parameter FLASH_S, default 5, seconds of flashing walk before phase end, 0..PED_S.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 P  input  1  pedestrian phase active, driven by main_ltc, synchronous to clk.
REQ-007 walk  output  1  walk lamp, steady or flashing.
REQ-008 dont_walk  output  1  don't-walk lamp.
REQ-009 bcd_tens, bcd_ones  output  4 each  remaining seconds, BCD.
REQ-010 seg_tens, seg_ones  output  7 each  active-high segments {g,f,e,d,c,b,a}; all-zero = blank.

Function
REQ-011 States SHALL be STOP, WALK, FLASH.
REQ-012 STOP: walk=0, dont_walk=1, both digits blank, BCD = 0.
REQ-013 A rising edge of P (P=1, previous P=0) seen in STOP SHALL load the count with PED_S and enter WALK on the next edge.
REQ-014 A 1 s tick SHALL come from a prescaler that counts 0..CLK_HZ-1, restarts from 0 on phase entry, and ticks on terminal count.
REQ-015 Each tick SHALL decrement the BCD count by 1: ones wraps 0->9 with a tens borrow; the count SHALL saturate at 00.
REQ-016 WALK: walk=1, dont_walk=0, digits show the count with a leading-zero tens digit blanked.
REQ-017 WALK->FLASH SHALL occur in the cycle the count becomes <= FLASH_S; if PED_S <= FLASH_S, FLASH SHALL be entered directly from STOP.
REQ-018 FLASH: walk toggles every CLK_HZ/2 cycles, starting at 1 on entry; dont_walk=0; digits as in WALK.
REQ-019 At count 00 with P still 1, the block SHALL stay in FLASH showing "0" until P falls.
REQ-020 P=0 in WALK or FLASH SHALL force STOP on the next edge regardless of the count (early end).
REQ-021 P rising again in the same cycle that STOP is entered SHALL be honoured on the following cycle; no rising edge SHALL be lost.
REQ-022 P high at reset release SHALL NOT start a phase; only a subsequent rising edge SHALL.
REQ-023 All outputs SHALL be registered, with a latency of one clk from the state or count change.

Reset
REQ-024 rst=1 SHALL asynchronously force STOP: walk=0, dont_walk=1, BCD=0, segments blank, prescaler=0, edge-detect register=1.
REQ-025 rst asserted mid-phase SHALL abandon the phase with no residual flash or count.

Structure
REQ-026 State encodings and the seven-segment patterns for 0-9 SHALL live in a shared include, ped_defs.vh, which the traffic blocks also use.
REQ-027 The BCD-to-segment decoder SHALL be the combinational sub-module seg7_dec, instantiated twice.
REQ-028 The prescaler, BCD counter, and FSM SHALL reside in ped_signal.

Verification
REQ-029 Benches SHALL run with CLK_HZ=10, PED_S=12, FLASH_S=3, and a 1 MHz clk.
REQ-030 Reset: pulse rst with P=0 -> dont_walk=1, walk=0, segments=0 immediately, without a clk edge.
REQ-031 Full phase: raise P and hold it for 130 clk -> WALK shows 12 down to 4, steady walk; FLASH shows 3,2,1,0 with walk toggling every 5 clk; 0 is held until P falls, then STOP.
REQ-032 Early end: drop P at count 8 -> STOP one clk later, digits blank, dont_walk=1.
REQ-033 Borrow: at count 10, after one tick -> bcd_tens=0, bcd_ones=9, tens digit blank, seg_ones=7'b1101111.
REQ-034 Mid-phase reset: assert rst during FLASH -> STOP outputs asynchronously; release rst with P held at 1 -> remains in STOP until a new P rising edge.
REQ-035 Back-to-back: drop P for 1 clk and raise it again -> a new phase restarts from 12 and the prescaler restarts from 0.

Source files
------------

// File: rtl/ped_signal_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the pedestrian signal: state encoding, BCD count type,
// seven-segment patterns.
package ped_signal_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2
  } ped_state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Active-high segments {g,f,e,d,c,b,a}; non-decimal codes read as blank.
  function automatic logic [6:0] seg7_pattern(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic int unsigned bcd_value(input bcd_t v);
    return 32'(v.tens) * 32'd10 + 32'(v.ones);
  endfunction

endpackage

// File: rtl/ped_signal_seg7_dec.sv
`timescale 1ns/1ps
// Combinational BCD digit to seven-segment decoder.
module seg7_dec
  import ped_signal_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = seg7_pattern(digit);
  end

endmodule

// File: rtl/ped_signal.sv
`timescale 1ns/1ps
// Pedestrian walk/don't-walk controller with a two-digit BCD countdown,
// driven by the main controller's pedestrian-phase signal P.
module ped_signal
  import ped_signal_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 1000000,
  parameter int unsigned PED_S   = 25,
  parameter int unsigned FLASH_S = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       P,
  output logic       walk,
  output logic       dont_walk,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
);

  localparam int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned HALF   = (CLK_HZ >= 2) ? CLK_HZ / 2 : 1;
  localparam int unsigned HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_HZ - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
  localparam logic [3:0]        PED_TENS  = 4'(PED_S / 10);
  localparam logic [3:0]        PED_ONES  = 4'(PED_S % 10);
  // A phase no longer than the flash window starts out flashing.
  localparam ped_state_e START_STATE = (PED_S <= FLASH_S) ? ST_FLASH : ST_WALK;

  ped_state_e        state;
  bcd_t              count;
  logic [PRE_W-1:0]  pre;
  logic [HALF_W-1:0] half_cnt;
  logic              flash_on;
  logic              p_q;

  logic       tick_c;
  logic       rise_c;
  logic       enters_flash_c;
  bcd_t       count_dec_c;
  logic [6:0] seg_tens_c;
  logic [6:0] seg_ones_c;

  // Saturating BCD decrement and flash-threshold test on the decremented value.
  always_comb begin
    count_dec_c = count;
    if (count.ones != 4'd0) begin
      count_dec_c.ones = count.ones - 4'd1;
    end else if (count.tens != 4'd0) begin
      count_dec_c.tens = count.tens - 4'd1;
      count_dec_c.ones = 4'd9;
    end
    tick_c         = (pre == PRE_LAST);
    rise_c         = P & ~p_q;
    enters_flash_c = (bcd_value(count_dec_c) <= FLASH_S);
  end

  seg7_dec u_seg_tens (.digit(count.tens), .seg_c(seg_tens_c));
  seg7_dec u_seg_ones (.digit(count.ones), .seg_c(seg_ones_c));

  // Phase FSM, prescaler, countdown and the registered lamp/display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_STOP;
      count     <= '0;
      pre       <= '0;
      half_cnt  <= '0;
      flash_on  <= 1'b0;
      p_q       <= 1'b1;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
      seg_tens  <= SEG_BLANK;
      seg_ones  <= SEG_BLANK;
    end else begin
      p_q <= P;

      case (state)
        ST_STOP: begin
          if (rise_c) begin
            state    <= START_STATE;
            count    <= {PED_TENS, PED_ONES};
            pre      <= '0;
            half_cnt <= '0;
            flash_on <= 1'b1;
          end
        end
        ST_WALK, ST_FLASH: begin
          if (!P) begin
            state    <= ST_STOP;
            count    <= '0;
            pre      <= '0;
            half_cnt <= '0;
            flash_on <= 1'b0;
          end else begin
            pre <= tick_c ? '0 : pre + PRE_W'(1);
            if (state == ST_FLASH) begin
              if (half_cnt == HALF_LAST) begin
                half_cnt <= '0;
                flash_on <= ~flash_on;
              end else begin
                half_cnt <= half_cnt + HALF_W'(1);
              end
            end
            if (tick_c) begin
              count <= count_dec_c;
              if (state == ST_WALK && enters_flash_c) begin
                state    <= ST_FLASH;
                half_cnt <= '0;
                flash_on <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_STOP;
      endcase

      // Outputs follow the state/count registers by one clock.
      walk      <= (state == ST_WALK) || (state == ST_FLASH && flash_on);
      dont_walk <= (state == ST_STOP);
      if (state == ST_STOP) begin
        bcd_tens <= 4'd0;
        bcd_ones <= 4'd0;
        seg_tens <= SEG_BLANK;
        seg_ones <= SEG_BLANK;
      end else begin
        bcd_tens <= count.tens;
        bcd_ones <= count.ones;
        seg_tens <= (count.tens == 4'd0) ? SEG_BLANK : seg_tens_c;
        seg_ones <= seg_ones_c;
      end
    end
  end

endmodule
